// File: rtl/zpu_sd_bridge.sv
// Bridge between the ZPU firmware I/O ports and the hps_io virtual-disk interface:
// sector buffer, LBA register, per-slot block request sequencing and mount queue.
module zpu_sd_bridge #(
  parameter int unsigned      VDNUM       = 3,
  parameter int unsigned      BUF_AW      = 9,
  parameter logic [VDNUM-1:0] RO_MASK     = 3'b100,
  parameter int unsigned      ACK_TIMEOUT = 1048575,
  parameter int unsigned      MNT_HOLD    = 65535
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       zpu_out2,
  input  logic [31:0]       zpu_out3,
  input  logic              zpu_io_wr,
  input  logic              zpu_data_wr,
  input  logic              zpu_data_rd,
  output logic [7:0]        zpu_in2,
  output logic [31:0]       zpu_in3,
  output logic [31:0]       sd_lba,
  output logic [VDNUM-1:0]  sd_rd,
  output logic [VDNUM-1:0]  sd_wr,
  input  logic              sd_ack,
  input  logic [BUF_AW-1:0] sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  input  logic [VDNUM-1:0]  img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic [1:0]        file_type
);

  localparam int unsigned TMR_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned HOLD_W = $clog2(MNT_HOLD + 2);
  localparam int unsigned DEPTH  = 1 << BUF_AW;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  logic              lba_sel, block_rd, block_wr;
  logic [2:0]        drv_num;
  logic              unused_bits;

  assign lba_sel  = zpu_out2[0];
  assign block_rd = zpu_out2[1];
  assign block_wr = zpu_out2[2];
  assign drv_num  = zpu_out2[5:3];
  assign unused_bits = ^{zpu_out2[31:6], img_size[63:32]};

  // ZPU data path: strobe synchronisers, write staging and buffer pointer
  logic              w1_q, w2_q, r1_q;
  logic              buf_we_q, lba_we_q, wr_inc_q, lba_sel_q;
  logic [31:0]       wdat_q, sd_lba_q;
  logic [BUF_AW-1:0] ptr_q;
  logic              wr_evt, rd_evt;

  assign wr_evt = w1_q & ~w2_q;
  assign rd_evt = r1_q & ~zpu_data_rd;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      w1_q      <= 1'b0;
      w2_q      <= 1'b0;
      r1_q      <= 1'b0;
      buf_we_q  <= 1'b0;
      lba_we_q  <= 1'b0;
      wr_inc_q  <= 1'b0;
      lba_sel_q <= 1'b0;
      wdat_q    <= '0;
      sd_lba_q  <= '0;
      ptr_q     <= '0;
    end else begin
      w1_q      <= zpu_data_wr;
      w2_q      <= w1_q;
      r1_q      <= zpu_data_rd;
      buf_we_q  <= wr_evt & ~lba_sel;
      lba_we_q  <= wr_evt & lba_sel;
      wr_inc_q  <= buf_we_q;
      lba_sel_q <= lba_sel;
      if (wr_evt) wdat_q <= zpu_out3;
      if (lba_we_q) sd_lba_q <= wdat_q;
      if (zpu_io_wr) ptr_q <= '0;
      else if (wr_inc_q | rd_evt) ptr_q <= ptr_q + BUF_AW'(1);
    end
  end

  // Sector buffer: port A for hps_io, port B for the ZPU pointer, registered reads
  logic [7:0] mem [DEPTH];
  logic [7:0] sd_buff_din_q, buf_rd_q;

  always_ff @(posedge clk_sys) begin
    if (sd_buff_wr) mem[sd_buff_addr] <= sd_buff_dout;
    if (buf_we_q) mem[ptr_q] <= wdat_q[7:0];
    sd_buff_din_q <= mem[sd_buff_addr];
    buf_rd_q      <= mem[ptr_q];
  end

  // Edge-detect history follows the inputs even in reset so held levels are not re-seen
  logic             blk_rd_q, blk_wr_q;
  logic [VDNUM-1:0] mnt_q;

  always_ff @(posedge clk_sys) begin
    blk_rd_q <= block_rd;
    blk_wr_q <= block_wr;
    mnt_q    <= img_mounted;
  end

  // Block request FSM
  state_t           state_q, state_d;
  logic [VDNUM-1:0] sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d, req_oh;
  logic             io_done_q, io_done_d, tmo_err_q, tmo_err_d, rng_err_q, rng_err_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rd_rise, wr_rise, start, drv_ok, tmo_hit;

  assign rd_rise = block_rd & ~blk_rd_q;
  assign wr_rise = block_wr & ~blk_wr_q;
  assign start   = rd_rise | wr_rise;
  assign drv_ok  = 32'(drv_num) < VDNUM;
  assign req_oh  = VDNUM'(1) << drv_num;
  assign tmo_hit = tmr_q == TMR_W'(ACK_TIMEOUT - 1);

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && drv_ok) state_d = S_REQ;
      S_REQ:   if (sd_ack) state_d = S_XFER;
               else if (tmo_hit) state_d = S_IDLE;
      S_XFER:  if (!sd_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    io_done_d = io_done_q;
    tmo_err_d = tmo_err_q;
    rng_err_d = rng_err_q;
    tmr_d     = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (drv_ok) begin
            io_done_d = 1'b0;
            tmo_err_d = 1'b0;
            rng_err_d = 1'b0;
            tmr_d     = '0;
            if (rd_rise) sd_rd_d = req_oh;
            else         sd_wr_d = req_oh;
          end else begin
            rng_err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
        end else if (tmo_hit) begin
          sd_rd_d   = '0;
          sd_wr_d   = '0;
          tmo_err_d = 1'b1;
          io_done_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_XFER: if (!sd_ack) io_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sd_rd_q   <= '0;
      sd_wr_q   <= '0;
      io_done_q <= 1'b1;
      tmo_err_q <= 1'b0;
      rng_err_q <= 1'b0;
      tmr_q     <= '0;
    end else begin
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      io_done_q <= io_done_d;
      tmo_err_q <= tmo_err_d;
      rng_err_q <= rng_err_d;
      tmr_q     <= tmr_d;
    end
  end

  // Mount queue: per-slot latches, lowest pending slot presented once per hold window
  logic [VDNUM-1:0]  mnt_rise, pend_q, pend_d, pend_eff, sel_oh;
  logic [VDNUM-1:0]  ro_q;
  logic [31:0]       size_q [VDNUM];
  logic [1:0]        type_q [VDNUM];
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              sel_hit, present, sel_ro;
  logic [2:0]        sel_idx;
  logic [31:0]       sel_size;
  logic [1:0]        sel_type;
  logic              mnt_tog_q, ro_pres_q;
  logic [2:0]        fileno_q;
  logic [1:0]        ftype_q;
  logic [31:0]       fsize_q;

  assign mnt_rise = img_mounted & ~mnt_q;
  assign pend_eff = pend_q | mnt_rise;

  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_ro   = 1'b0;
    sel_size = '0;
    sel_type = '0;
    for (int i = int'(VDNUM) - 1; i >= 0; i--) begin
      if (pend_eff[i]) begin
        sel_hit  = 1'b1;
        sel_idx  = 3'(i);
        sel_ro   = mnt_rise[i] ? (img_readonly | RO_MASK[i]) : ro_q[i];
        sel_size = mnt_rise[i] ? img_size[31:0] : size_q[i];
        sel_type = mnt_rise[i] ? file_type : type_q[i];
      end
    end
  end

  assign present = (hold_q == '0) && sel_hit;
  assign sel_oh  = present ? (VDNUM'(1) << sel_idx) : '0;

  always_comb begin
    pend_d = pend_eff & ~sel_oh;
    hold_d = hold_q;
    if (present)             hold_d = HOLD_W'(MNT_HOLD);
    else if (hold_q != '0)   hold_d = hold_q - HOLD_W'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_q    <= '0;
      hold_q    <= '0;
      ro_q      <= '0;
      mnt_tog_q <= 1'b0;
      ro_pres_q <= 1'b0;
      fileno_q  <= '0;
      ftype_q   <= '0;
      fsize_q   <= '0;
      for (int i = 0; i < int'(VDNUM); i++) begin
        size_q[i] <= '0;
        type_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
      for (int i = 0; i < int'(VDNUM); i++) begin
        if (mnt_rise[i]) begin
          ro_q[i]   <= img_readonly | RO_MASK[i];
          size_q[i] <= img_size[31:0];
          type_q[i] <= file_type;
        end
      end
      if (present) begin
        mnt_tog_q <= ~mnt_tog_q;
        fileno_q  <= sel_idx;
        ftype_q   <= sel_type;
        ro_pres_q <= sel_ro;
        fsize_q   <= sel_size;
      end
    end
  end

  assign zpu_in2     = {ro_pres_q, ftype_q, fileno_q, mnt_tog_q, io_done_q};
  assign zpu_in3     = lba_sel_q ? fsize_q : {tmo_err_q, rng_err_q, 22'd0, buf_rd_q};
  assign sd_lba      = sd_lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_buff_din = sd_buff_din_q;

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Directed bench for zpu_sd_bridge: buffer round-trip, block handshake, timeout,
// range error, reset during a request and simultaneous mounts.
module tb_zpu_sd_bridge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] zpu_out2, zpu_out3;
  logic        zpu_io_wr, zpu_data_wr, zpu_data_rd;
  logic [7:0]  zpu_in2;
  logic [31:0] zpu_in3, sd_lba;
  logic [2:0]  sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr;
  logic [2:0]  img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic [1:0]  file_type;

  int n_vec = 0;
  int n_err = 0;

  zpu_sd_bridge #(
    .VDNUM(3), .BUF_AW(9), .RO_MASK(3'b100), .ACK_TIMEOUT(100), .MNT_HOLD(10)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
    .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
    .zpu_in2(zpu_in2), .zpu_in3(zpu_in3),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size), .file_type(file_type)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic io_wr();
    zpu_io_wr = 1'b1;
    step(1);
    zpu_io_wr = 1'b0;
    step(1);
  endtask

  task automatic zwrite(input logic [31:0] d);
    zpu_out3    = d;
    zpu_data_wr = 1'b1;
    step(1);
    zpu_data_wr = 1'b0;
    step(4);
  endtask

  task automatic rd_pulse();
    zpu_data_rd = 1'b1;
    step(1);
    zpu_data_rd = 1'b0;
    step(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int n;
    reset = 1'b1; zpu_out2 = '0; zpu_out3 = '0;
    zpu_io_wr = 1'b0; zpu_data_wr = 1'b0; zpu_data_rd = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    img_mounted = '0; img_readonly = 1'b0; img_size = '0; file_type = '0;
    step(3);
    reset = 1'b0;
    zpu_out2 = 32'h1;
    step(1);
    chk("rst_sd_rd",   64'(sd_rd),   64'(3'b000));
    chk("rst_sd_wr",   64'(sd_wr),   64'(3'b000));
    chk("rst_sd_lba",  64'(sd_lba),  64'(32'h0));
    chk("rst_status",  64'(zpu_in2), 64'(8'h01));
    chk("rst_fsize",   64'(zpu_in3), 64'(32'h0));
    zpu_out2 = 32'h0;

    // Buffer round-trip through the ZPU port
    io_wr();
    for (int i = 0; i < 512; i++) begin
      b = 8'(i);
      zwrite({24'd0, b ^ 8'h5A});
    end
    io_wr();
    for (int i = 0; i < 512; i++) begin
      b = 8'(i);
      chk("buf_rd", 64'(zpu_in3), 64'({24'd0, b ^ 8'h5A}));
      rd_pulse();
    end
    chk("ptr_wrap_rd", 64'(zpu_in3), 64'(32'h5A));
    sd_buff_addr = 9'd3;
    step(1);
    chk("portA_rd", 64'(sd_buff_din), 64'(8'h59));
    sd_buff_addr = 9'd7; sd_buff_dout = 8'hE7; sd_buff_wr = 1'b1;
    step(1);
    sd_buff_wr = 1'b0;
    step(1);
    chk("portA_wr", 64'(sd_buff_din), 64'(8'hE7));
    zwrite(32'hC3);
    io_wr();
    chk("ptr_wrap_wr", 64'(zpu_in3), 64'(32'hC3));

    // LBA write then read handshake on slot 1
    zpu_out2 = 32'h1;
    zwrite(32'h0000_1234);
    chk("lba", 64'(sd_lba), 64'(32'h1234));
    zpu_out2 = 32'h0A;
    step(1);
    chk("hs_sd_rd",   64'(sd_rd),      64'(3'b010));
    chk("hs_busy",    64'(zpu_in2[0]), 64'(1'b0));
    sd_ack = 1'b1;
    step(5);
    chk("hs_rd_clr",  64'(sd_rd),      64'(3'b000));
    chk("hs_xfer",    64'(zpu_in2[0]), 64'(1'b0));
    sd_ack = 1'b0;
    step(1);
    chk("hs_done",    64'(zpu_in2[0]), 64'(1'b1));
    zpu_out2 = 32'h0;
    step(1);

    // Write request on slot 0 with no acknowledge
    zpu_out2 = 32'h04;
    step(1);
    n = 0;
    while (sd_wr == 3'b001 && n < 200) begin
      n++;
      step(1);
    end
    chk("tmo_len",    64'(n),            64'(100));
    chk("tmo_wr_clr", 64'(sd_wr),        64'(3'b000));
    chk("tmo_done",   64'(zpu_in2[0]),   64'(1'b1));
    chk("tmo_err",    64'(zpu_in3[31]),  64'(1'b1));
    zpu_out2 = 32'h0;
    step(1);

    // Out-of-range drive number
    zpu_out2 = 32'h2A;
    step(1);
    chk("rng_sd_rd",  64'(sd_rd),        64'(3'b000));
    chk("rng_err",    64'(zpu_in3[30]),  64'(1'b1));
    chk("rng_done",   64'(zpu_in2[0]),   64'(1'b1));
    zpu_out2 = 32'h0;
    step(1);

    // Reset while slot 2 is requesting
    zpu_out2 = 32'h12;
    step(1);
    chk("rq2_sd_rd",  64'(sd_rd),         64'(3'b100));
    chk("rq2_errclr", 64'(zpu_in3[31:30]), 64'(2'b00));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    zpu_out2 = 32'h0;
    chk("rst_req_clr", 64'(sd_rd),       64'(3'b000));
    chk("rst_req_done",64'(zpu_in2[0]),  64'(1'b1));
    chk("rst_lba_clr", 64'(sd_lba),      64'(32'h0));
    sd_ack = 1'b1;
    step(2);
    sd_ack = 1'b0;
    step(2);
    chk("late_ack_rd", 64'(sd_rd),       64'(3'b000));
    chk("late_ack_st", 64'(zpu_in2),     64'(8'h01));

    // Simultaneous mounts on slots 0 and 2
    img_size = 64'd4096; file_type = 2'b10; img_readonly = 1'b0;
    img_mounted = 3'b101;
    step(1);
    img_mounted = 3'b000; img_size = '0; file_type = 2'b00;
    zpu_out2 = 32'h1;
    chk("mnt0_status", 64'(zpu_in2), 64'(8'h43));
    step(1);
    chk("mnt0_size",   64'(zpu_in3), 64'(32'h1000));
    step(9);
    chk("mnt_hold",    64'(zpu_in2), 64'(8'h43));
    step(1);
    chk("mnt2_status", 64'(zpu_in2), 64'(8'hC9));
    chk("mnt2_size",   64'(zpu_in3), 64'(32'h1000));
    step(12);
    chk("mnt_idle",    64'(zpu_in2), 64'(8'hC9));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
